dff_ms_write_sequencer: RTL

- Sequences write transactions into a shared WIDTH-bit master-slave D flip-flop bank built from two D-latch ranks.
- Arbitrates between two requesters with round-robin priority.
- Drives the master and slave latch enables as non-overlapping phases with programmable hold and dead-time, then checks the bank readback and acknowledges the winner.

---
 rtl/dff_ms_write_sequencer_pkg.sv | 24 ++
 rtl/dff_ms_write_sequencer_rr_arbiter2.sv | 34 +++
 rtl/dff_ms_write_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dff_ms_write_sequencer_pkg.sv
// Shared types and constants for the master-slave latch bank write sequencer.
package dff_ms_write_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MASTER,
        GAP_A,
        SLAVE,
        GAP_B,
        ACK
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

    // Counter must hold the largest reload value of either phase.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dff_ms_write_sequencer_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer flop favours the requester not served last.
module rr_arbiter2
    import dff_ms_write_sequencer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic [1:0] served_i,
    output logic [1:0] winner_o
);

    logic ptr_q;

    always_comb begin
        winner_o = GRANT_NONE;
        if (req_i == 2'b11) begin
            winner_o = ptr_q ? GRANT_1 : GRANT_0;
        end else if (req_i[0]) begin
            winner_o = GRANT_0;
        end else if (req_i[1]) begin
            winner_o = GRANT_1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (update_i) begin
            ptr_q <= (served_i == GRANT_0);
        end
    end

endmodule

// File: rtl/dff_ms_write_sequencer.sv
// Write sequencer for a two-rank latch bank: arbitrates, drives non-overlapping
// master/slave enables, verifies readback and acknowledges the winner.
module dff_ms_write_sequencer
    import dff_ms_write_sequencer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic             input_clock1_clk_1,
    input  logic             input_push_button1_rst_n_2,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    input  logic [WIDTH-1:0] q_in,
    input  logic             err_clr,
    output logic             master_en,
    output logic             slave_en,
    output logic [WIDTH-1:0] latch_d,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             err
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       grant_q;
    logic [WIDTH-1:0] latch_d_q;
    logic             master_en_q;
    logic             slave_en_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             busy_q;
    logic             err_q;

    logic [1:0]       winner;
    logic             mismatch_d;
    logic             arb_update;

    assign arb_update = (state_q == ACK);

    rr_arbiter2 u_arb (
        .clk_i    (input_clock1_clk_1),
        .rst_ni   (input_push_button1_rst_n_2),
        .req_i    ({req1, req0}),
        .update_i (arb_update),
        .served_i (grant_q),
        .winner_o (winner)
    );

    always_comb begin
        mismatch_d = (state_q == GAP_B) && (cnt_q == '0) && (q_in != latch_d_q);
    end

    always_ff @(posedge input_clock1_clk_1 or negedge input_push_button1_rst_n_2) begin
        if (!input_push_button1_rst_n_2) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= GRANT_NONE;
            latch_d_q   <= '0;
            master_en_q <= 1'b0;
            slave_en_q  <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Set dominates a coincident clear.
            err_q <= (err_q & ~err_clr) | mismatch_d;
            case (state_q)
                IDLE: begin
                    if (winner != GRANT_NONE) begin
                        grant_q     <= winner;
                        latch_d_q   <= (winner == GRANT_0) ? data0 : data1;
                        master_en_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cnt_q       <= HOLD_LD;
                        state_q     <= MASTER;
                    end
                end
                MASTER: begin
                    if (cnt_q == '0) begin
                        master_en_q <= 1'b0;
                        cnt_q       <= GAP_LD;
                        state_q     <= GAP_A;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP_A: begin
                    if (cnt_q == '0) begin
                        slave_en_q <= 1'b1;
                        cnt_q      <= HOLD_LD;
                        state_q    <= SLAVE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SLAVE: begin
                    if (cnt_q == '0) begin
                        slave_en_q <= 1'b0;
                        cnt_q      <= GAP_LD;
                        state_q    <= GAP_B;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP_B: begin
                    if (cnt_q == '0) begin
                        ack0_q  <= grant_q[0];
                        ack1_q  <= grant_q[1];
                        cnt_q   <= '0;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACK: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    grant_q <= GRANT_NONE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign master_en = master_en_q;
    assign slave_en  = slave_en_q;
    assign latch_d   = latch_d_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
